// File: rtl/replica_dist_scan.sv
// Non-destructive rotating readout of CHAIN_NUM distance shift chains, streamed over valid/ready with chain/index tags.
// Optional minimum tracking is enabled by defining DIST_SCAN_BEST_EN; otherwise best_* are tied to 0.
module replica_dist_scan #(
  parameter int CHAIN_NUM   = 2,
  parameter int REPLICA_NUM = 32,
  parameter int DATA_W      = 32,
  localparam int CW = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1,
  localparam int IW = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [CHAIN_NUM-1:0]        chain_shift,
  output logic [CHAIN_NUM*DATA_W-1:0] chain_wdata,
  input  logic [CHAIN_NUM*DATA_W-1:0] chain_rdata,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [CW-1:0]               m_chain,
  output logic [IW-1:0]               m_index,
  output logic                        best_valid,
  output logic [DATA_W-1:0]           best_data,
  output logic [CW-1:0]               best_chain,
  output logic [IW-1:0]               best_index
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_SEND, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     c_q;
  logic [IW-1:0]     k_q;
  logic [DATA_W-1:0] m_data_q;
  logic [CW-1:0]     m_chain_q;
  logic [IW-1:0]     m_index_q;
  logic [DATA_W-1:0] rd_sel;
  logic              last_k, last_c;

  assign last_k = (k_q == IW'(REPLICA_NUM - 1));
  assign last_c = (c_q == CW'(CHAIN_NUM - 1));

  // The selected chain is shifted with its own output fed back, so it rotates in place.
  always_comb begin
    rd_sel      = '0;
    chain_shift = '0;
    chain_wdata = '0;
    for (int c = 0; c < CHAIN_NUM; c++) begin
      if (c_q == CW'(c)) begin
        rd_sel = chain_rdata[c*DATA_W +: DATA_W];
        if (state_q == S_CAPT) begin
          chain_shift[c]                 = 1'b1;
          chain_wdata[c*DATA_W +: DATA_W] = chain_rdata[c*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef DIST_SCAN_BEST_EN
  logic              best_valid_q;
  logic [DATA_W-1:0] best_data_q;
  logic [CW-1:0]     best_chain_q;
  logic [IW-1:0]     best_index_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      k_q       <= '0;
      m_data_q  <= '0;
      m_chain_q <= '0;
      m_index_q <= '0;
`ifdef DIST_SCAN_BEST_EN
      best_valid_q <= 1'b0;
      best_data_q  <= '0;
      best_chain_q <= '0;
      best_index_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CAPT;
            c_q     <= '0;
            k_q     <= '0;
`ifdef DIST_SCAN_BEST_EN
            best_valid_q <= 1'b0;
`endif
          end
        end
        S_CAPT: begin
          m_data_q  <= rd_sel;
          m_chain_q <= c_q;
          m_index_q <= IW'(REPLICA_NUM - 1) - k_q;
`ifdef DIST_SCAN_BEST_EN
          // Strict compare keeps the earliest-read word on ties.
          if ((c_q == '0 && k_q == '0) || (rd_sel < best_data_q)) begin
            best_data_q  <= rd_sel;
            best_chain_q <= c_q;
            best_index_q <= IW'(REPLICA_NUM - 1) - k_q;
          end
`endif
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (m_ready) begin
            if (last_k && last_c) begin
              state_q <= S_DONE;
`ifdef DIST_SCAN_BEST_EN
              best_valid_q <= 1'b1;
`endif
            end else begin
              state_q <= S_CAPT;
              if (last_k) begin
                k_q <= '0;
                c_q <= c_q + CW'(1);
              end else begin
                k_q <= k_q + IW'(1);
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign m_valid = (state_q == S_SEND);
  assign m_data  = m_data_q;
  assign m_chain = m_chain_q;
  assign m_index = m_index_q;

`ifdef DIST_SCAN_BEST_EN
  assign best_valid = best_valid_q;
  assign best_data  = best_data_q;
  assign best_chain = best_chain_q;
  assign best_index = best_index_q;
`else
  assign best_valid = 1'b0;
  assign best_data  = '0;
  assign best_chain = '0;
  assign best_index = '0;
`endif

endmodule

// File: tb/tb_replica_dist_scan.sv
// Directed bench for replica_dist_scan with CHAIN_NUM=2, REPLICA_NUM=4 and a behavioural shift-chain model.
module tb_replica_dist_scan;

  logic        clk = 1'b0;
  logic        reset, start, m_ready;
  logic        busy, done, m_valid, best_valid;
  logic [1:0]  chain_shift;
  logic [63:0] chain_wdata, chain_rdata;
  logic [31:0] m_data, best_data;
  logic [0:0]  m_chain, best_chain;
  logic [1:0]  m_index, best_index;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  replica_dist_scan #(.CHAIN_NUM(2), .REPLICA_NUM(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .chain_shift(chain_shift), .chain_wdata(chain_wdata), .chain_rdata(chain_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chain(m_chain),
    .m_index(m_index), .best_valid(best_valid), .best_data(best_data),
    .best_chain(best_chain), .best_index(best_index)
  );

  // Chain model: chn[c][0] is node 0, chn[c][3] drives rdata.
  logic [31:0] chn    [2][4];
  logic [31:0] ld_val [2][4];
  logic        ld_en = 1'b0;

  always @(posedge clk) begin
    if (ld_en) begin
      chn <= ld_val;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (chain_shift[c]) begin
          for (int i = 3; i > 0; i--) chn[c][i] <= chn[c][i-1];
          chn[c][0] <= chain_wdata[c*32 +: 32];
        end
      end
    end
  end
  assign chain_rdata = {chn[1][3], chn[0][3]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mdata"}, {m_data, 1'b0, m_chain, m_index}, 0);
    chk({tag, "_shift"}, chain_shift, 0);
    chk({tag, "_wdata"}, chain_wdata, 0);
    chk({tag, "_best"}, {best_valid, best_data, best_chain, best_index}, 0);
  endtask

  task automatic load(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
    ld_val[0][0] = a0; ld_val[0][1] = a1; ld_val[0][2] = a2; ld_val[0][3] = a3;
    ld_val[1][0] = b0; ld_val[1][1] = b1; ld_val[1][2] = b2; ld_val[1][3] = b3;
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  // One scan; word w is chain w/4, node 3-(w%4). Optional stall on word stall_w, optional start spamming.
  task automatic scan(input string tag, input int stall_w, input int stall_len, input bit spam,
                      input logic [31:0] eb_data, input logic eb_chain, input logic [1:0] eb_index);
    int w, cyc, done_cyc, ndone, stall_cnt, nsh0, nsh1, c, k;
    w = 0; cyc = 1; done_cyc = -1; ndone = 0; stall_cnt = 0; nsh0 = 0; nsh1 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_shift1"}, chain_shift, 2'b01);
    chk({tag, "_bvalid_lo"}, best_valid, 0);
    repeat (40) begin
      if (chain_shift[0]) nsh0++;
      if (chain_shift[1]) nsh1++;
      m_ready = 1'b1;
      if (m_valid && w < 8) begin
        c = w / 4;
        k = w % 4;
        if (w == stall_w && stall_cnt < stall_len) begin
          m_ready = 1'b0;
          stall_cnt++;
          chk({tag, "_stall_data"}, m_data, ld_val[c][3-k]);
          chk({tag, "_stall_shift"}, chain_shift, 0);
        end else begin
          chk($sformatf("%s_w%0d", tag, w), {m_data, 7'd0, m_chain, m_index},
              {ld_val[c][3-k], 7'd0, c[0], 2'(3 - k)});
          w++;
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      start = spam && busy;
      tick();
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk({tag, "_nwords"}, w, 8);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_done_cyc"}, done_cyc, 17 + stall_len);
    chk({tag, "_idle_after"}, {busy, m_valid}, 0);
    chk({tag, "_nshift"}, {nsh0[7:0], nsh1[7:0]}, {8'd4, 8'd4});
    for (int cc = 0; cc < 2; cc++)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_restore_c%0d_n%0d", tag, cc, i), chn[cc][i], ld_val[cc][i]);
`ifdef DIST_SCAN_BEST_EN
    chk({tag, "_best"}, {best_valid, best_data, best_chain, best_index}, {1'b1, eb_data, eb_chain, eb_index});
`else
    chk({tag, "_best_off"}, {best_valid, best_data, best_chain, best_index}, 0);
`endif
  endtask

  initial begin
    int w, cyc;
    reset = 1'b1; start = 1'b0; m_ready = 1'b1;
    tick(); tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();
    chk_idle("idle");

    load(10, 20, 30, 40, 5, 6, 7, 8);
    scan("plain", -1, 0, 1'b0, 5, 1'b1, 2'd0);

    load(10, 20, 30, 40, 5, 6, 7, 8);
    scan("stall", 2, 5, 1'b0, 5, 1'b1, 2'd0);

    load(10, 20, 30, 40, 5, 3, 3, 9);
    scan("tie", -1, 0, 1'b0, 3, 1'b1, 2'd2);

    load(10, 20, 30, 40, 5, 6, 7, 8);
    scan("spam", -1, 0, 1'b1, 5, 1'b1, 2'd0);

    // Reset once five words have been accepted.
    load(10, 20, 30, 40, 5, 6, 7, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0; cyc = 0;
    while (w < 5 && cyc < 40) begin
      if (m_valid) w++;
      tick();
      cyc++;
    end
    chk("midrst_reach", w, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("midrst");
    tick();
    chk_idle("midrst_hold");

    load(10, 20, 30, 40, 5, 6, 7, 8);
    scan("after_rst", -1, 0, 1'b0, 5, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/replica_dist_scan.md
# replica_dist_scan

Host-side readout sequencer for total-distance shift chains in the replica-exchange array, generalised from a single chain to CHAIN_NUM independent chains of REPLICA_NUM nodes each. On `start` it walks every chain non-destructively, rotating each word back into the chain, and streams every word out over a valid/ready port tagged with chain and replica index. It also tracks the minimum total distance and where it sits. It replaces raw host toggling of `distance_shift`/`distance_wdata` and sits between the bus register block and the node chains.

## Interface
- CHAIN_NUM, 2, number of independent distance chains (>=1)
- REPLICA_NUM, 32, nodes per chain (>=2)
- DATA_W, 32, total-distance word width (unsigned)
- CW (local), max(1,$clog2(CHAIN_NUM)); IW (local), max(1,$clog2(REPLICA_NUM))

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a scan; ignored while busy
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle pulse when the scan completes
- chain_shift  out  CHAIN_NUM  per-chain shift strobe
- chain_wdata  out  CHAIN_NUM*DATA_W  word entering slot 0 of each chain
- chain_rdata  in  CHAIN_NUM*DATA_W  word at the output of the last node of each chain
- m_valid  out  1  stream word valid
- m_ready  in  1  stream word accepted when m_valid&&m_ready
- m_data  out  DATA_W  distance word
- m_chain  out  CW  chain of m_data
- m_index  out  IW  replica (node id) of m_data
- best_valid  out  1  best_* hold the result of a completed scan
- best_data  out  DATA_W  minimum distance seen
- best_chain  out  CW; best_index  out  IW  location of minimum

## Operation
- Chain model: one `chain_shift[c]` pulse moves every word of chain c one node downstream; `chain_rdata[c]` shows node REPLICA_NUM-1, and `chain_wdata[c]` enters node 0.
- Rotate: when shifting chain c, drive `chain_wdata[c] = chain_rdata[c]` in the same cycle. After REPLICA_NUM shifts the chain is restored.
- Non-selected chains: shift 0, wdata 0.
- Order: chain 0 first, then ascending chain. Within a chain, the k-th word read (k=0..REPLICA_NUM-1) gets `m_index = REPLICA_NUM-1-k`.
- FSM states and transitions:
  - IDLE: on start, go to CAPT with c=0, k=0.
  - CAPT: register chain_rdata[c] into m_data with tags, pulse chain_shift[c] with rotate, then go to SEND.
  - SEND: hold m_valid=1 until m_ready. On handshake: if k=REPLICA_NUM-1 and c=CHAIN_NUM-1, go to DONE; else advance k (wrapping to 0 and incrementing c) and go to CAPT.
  - DONE: pulse done, go to IDLE.
- Exactly one shift per word per chain, so every chain ends a full scan restored.
- Min tracking:
  - The first word of a scan loads best unconditionally.
  - Each later word replaces best only if strictly less (unsigned), so ties keep the earliest (lowest chain, then highest node id).
  - best_valid drops at start and rises in DONE. best_* are stable while best_valid=1.
- m_data/m_chain/m_index hold their value while m_valid=1 and m_ready=0.
- start while busy has no effect. start in the same cycle as DONE is ignored.

## Timing
- Reset values: busy, done, m_valid, best_valid 0; all data/tag outputs 0; chain_shift 0; chain_wdata 0; FSM in IDLE; counters 0.
- start at cycle t: CAPT at t+1 (busy=1, chain_shift[0]=1), m_valid=1 at t+2.
- With m_ready tied high, one word every 2 cycles. A full scan takes 2*CHAIN_NUM*REPLICA_NUM+1 cycles from start to the done pulse.
- Backpressure stretches SEND only. No shift occurs during a stall.
- Reset mid-scan returns all state to reset values immediately. Chains are left partially rotated, and the host must reload them. No done pulse is issued.
- Counter wrap: k wraps REPLICA_NUM-1 to 0 only on the handshake of the last word of a chain. c never wraps.

## Configuration
- DIST_SCAN_BEST_EN defined: min tracking as above.
- DIST_SCAN_BEST_EN undefined: the compare logic is removed, and best_valid, best_data, best_chain, best_index are constant 0. Streaming behaviour is identical.

## Test plan
- CHAIN_NUM=2, REPLICA_NUM=4, chain0 node0..3 = {10,20,30,40}, chain1 = {5,6,7,8}, m_ready=1 -> stream (data,chain,index) = (40,0,3),(30,0,2),(20,0,1),(10,0,0),(8,1,3)..(5,1,0); done at start+17; both chains unchanged.
- Same data with m_ready low for 5 cycles during word 2 -> m_data stays 20, no chain_shift during the stall, stream order unchanged.
- Chain1 = {5,3,3,9} -> best_data=3, best_chain=1, best_index=2 (tie keeps first read); best_valid=1 after done.
- start re-asserted during busy and on the DONE cycle -> no restart, exactly 8 words, one done pulse.
- reset asserted at word 5 -> next cycle all outputs 0, IDLE; a new start scans correctly after the chains are reloaded.
- Compile without DIST_SCAN_BEST_EN -> best_* stay 0 throughout; stream identical to scenario 1.
